// File: rtl/uart_alu_top.sv
// Serial-controlled ALU: receives A, B and an opcode over UART 8N1, then returns A op B as one frame.
// Optional RX_FRAMING_CHECK_EN: drop bytes whose stop bit samples 0 and re-arm only once the line is high.
`timescale 1ns/1ps
module uart_alu_top #(
  parameter int NB_DATA  = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_CODE  = 6,
  parameter int NB_STATE = 2,
  parameter int BAUD_DIV = 326
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_tx
);
  localparam int NB_TCK = $clog2(SB_TICK);
  localparam int NB_BIT = $clog2(NB_DATA);
  localparam int NB_DIV = $clog2(BAUD_DIV);

  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3;
`ifdef RX_FRAMING_CHECK_EN
  localparam logic [2:0] RX_WAIT_HI = 3'd4;
`endif
  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [NB_STATE-1:0] WAIT_A = 'd0, WAIT_B = 'd1, WAIT_OP = 'd2, SEND = 'd3;

  localparam logic [NB_CODE-1:0] OP_ADD = 'b100000, OP_SUB = 'b100010, OP_AND = 'b100100,
                                 OP_OR  = 'b100101, OP_XOR = 'b100110, OP_NOR = 'b100111,
                                 OP_SRA = 'b000011, OP_SRL = 'b000010;

  logic [NB_DIV-1:0]  div_cnt;
  logic               tick;
  logic               rx_q1, rx_s;
  logic [2:0]         rx_st;
  logic [NB_TCK-1:0]  rx_tck;
  logic [NB_BIT-1:0]  rx_bit;
  logic [NB_DATA-1:0] rx_sh;
  logic               rx_done;
  logic [1:0]         tx_st;
  logic [NB_TCK-1:0]  tx_tck;
  logic [NB_BIT-1:0]  tx_bit;
  logic [NB_DATA-1:0] tx_sh;
  logic               tx_done, tx_start;
  logic [NB_STATE-1:0] state;
  logic [NB_DATA-1:0] a_reg, b_reg, result, alu_out;
  logic               sent;

  assign tick = (div_cnt == NB_DIV'(BAUD_DIV-1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) div_cnt <= '0;
    else          div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= i_rx;
      rx_s  <= rx_q1;
    end
  end

  // Receiver: start is re-checked at mid-bit, then every bit is sampled near its centre.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_st <= RX_IDLE; rx_tck <= '0; rx_bit <= '0; rx_sh <= '0; rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_st)
        RX_IDLE: if (!rx_s) begin rx_st <= RX_START; rx_tck <= '0; end
        RX_START: if (tick) begin
          if (rx_tck == NB_TCK'(SB_TICK/2-1)) begin
            rx_tck <= '0; rx_bit <= '0;
            rx_st  <= rx_s ? RX_IDLE : RX_DATA;
          end else rx_tck <= rx_tck + 1'b1;
        end
        RX_DATA: if (tick) begin
          if (rx_tck == NB_TCK'(SB_TICK-1)) begin
            rx_tck <= '0;
            rx_sh  <= {rx_s, rx_sh[NB_DATA-1:1]};
            if (rx_bit == NB_BIT'(NB_DATA-1)) rx_st <= RX_STOP;
            else rx_bit <= rx_bit + 1'b1;
          end else rx_tck <= rx_tck + 1'b1;
        end
        RX_STOP: if (tick) begin
          if (rx_tck == NB_TCK'(SB_TICK-1)) begin
`ifdef RX_FRAMING_CHECK_EN
            rx_done <= rx_s;
            rx_st   <= rx_s ? RX_IDLE : RX_WAIT_HI;
`else
            rx_done <= 1'b1;
            rx_st   <= RX_IDLE;
`endif
          end else rx_tck <= rx_tck + 1'b1;
        end
`ifdef RX_FRAMING_CHECK_EN
        RX_WAIT_HI: if (rx_s) rx_st <= RX_IDLE;
`endif
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_st <= TX_IDLE; tx_tck <= '0; tx_bit <= '0; tx_sh <= '0; tx_done <= 1'b0; o_tx <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      case (tx_st)
        TX_IDLE: begin
          o_tx <= 1'b1;
          if (tx_start) begin
            tx_sh <= result; tx_tck <= '0; o_tx <= 1'b0; tx_st <= TX_START;
          end
        end
        TX_START: if (tick) begin
          if (tx_tck == NB_TCK'(SB_TICK-1)) begin
            tx_tck <= '0; tx_bit <= '0; o_tx <= tx_sh[0]; tx_st <= TX_DATA;
          end else tx_tck <= tx_tck + 1'b1;
        end
        TX_DATA: if (tick) begin
          if (tx_tck == NB_TCK'(SB_TICK-1)) begin
            tx_tck <= '0;
            if (tx_bit == NB_BIT'(NB_DATA-1)) begin
              o_tx <= 1'b1; tx_st <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              tx_sh  <= tx_sh >> 1;
              o_tx   <= tx_sh[1];
            end
          end else tx_tck <= tx_tck + 1'b1;
        end
        TX_STOP: if (tick) begin
          if (tx_tck == NB_TCK'(SB_TICK-1)) begin
            tx_done <= 1'b1; tx_st <= TX_IDLE;
          end else tx_tck <= tx_tck + 1'b1;
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  // The opcode is consumed straight off the receiver so the result is ready the cycle after rx_done.
  always_comb begin
    alu_out = '0;
    case (rx_sh[NB_CODE-1:0])
      OP_ADD: alu_out = a_reg + b_reg;
      OP_SUB: alu_out = a_reg - b_reg;
      OP_AND: alu_out = a_reg & b_reg;
      OP_OR:  alu_out = a_reg | b_reg;
      OP_XOR: alu_out = a_reg ^ b_reg;
      OP_NOR: alu_out = ~(a_reg | b_reg);
      OP_SRA: alu_out = $signed(a_reg) >>> b_reg;
      OP_SRL: alu_out = a_reg >> b_reg;
      default: alu_out = '0;
    endcase
  end

  assign tx_start = (state == SEND) && !sent;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= WAIT_A; a_reg <= '0; b_reg <= '0; result <= '0; sent <= 1'b0;
    end else begin
      case (state)
        WAIT_A:  if (rx_done) begin a_reg <= rx_sh; state <= WAIT_B; end
        WAIT_B:  if (rx_done) begin b_reg <= rx_sh; state <= WAIT_OP; end
        WAIT_OP: if (rx_done) begin result <= alu_out; sent <= 1'b0; state <= SEND; end
        SEND: begin
          sent <= 1'b1;
          if (tx_done) state <= WAIT_A;
        end
        default: state <= WAIT_A;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_top.sv
// Randomised and directed bench for uart_alu_top: drives UART bytes, decodes the reply frame,
// and compares against a byte-stream reference model (honours RX_FRAMING_CHECK_EN).
`timescale 1ns/1ps
module tb_uart_alu_top;
  localparam int BAUD_DIV = 3;
  localparam int SB_TICK  = 16;
  localparam int BIT      = BAUD_DIV * SB_TICK;

  logic i_clk = 1'b0, i_reset = 1'b1, i_rx = 1'b1;
  logic o_tx;
  int   n_chk = 0, n_err = 0;
  logic [7:0] mq[$];
  logic [7:0] got_q[$];
  bit   abort;

  uart_alu_top #(.NB_DATA(8), .SB_TICK(SB_TICK), .NB_CODE(6), .NB_STATE(2), .BAUD_DIV(BAUD_DIV)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx(i_rx), .o_tx(o_tx));

  always #10 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int opb);
    int op, sa;
    op = opb % 64;
    sa = (a >= 128) ? a - 256 : a;
    case (op)
      32: return (a + b) % 256;
      34: return (a - b + 256) % 256;
      36: return a & b;
      37: return a | b;
      38: return a ^ b;
      39: return 255 - (a | b);
      2:  return (b >= 8) ? 0 : a / (1 << b);
      3:  return (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
      default: return 0;
    endcase
  endfunction

  always @(negedge i_reset) abort = 1'b1;

  // Frame decoder on o_tx: samples the centre of every bit after a falling edge.
  initial begin : mon
    logic [7:0] d;
    logic st, sp;
    forever begin
      @(negedge o_tx);
      if (i_reset !== 1'b1) continue;
      abort = 1'b0;
      repeat (BIT/2) @(negedge i_clk);
      st = o_tx;
      for (int k = 0; k < 8; k++) begin
        repeat (BIT) @(negedge i_clk);
        d[k] = o_tx;
      end
      repeat (BIT) @(negedge i_clk);
      sp = o_tx;
      if (!abort) begin
        chk("tx_start_stop_bits", {30'd0, st, sp}, 32'd1);
        got_q.push_back(d);
      end
    end
  end

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    i_rx = 1'b1;
    #50 chk("o_tx_in_reset", o_tx, 1);
    #50 i_reset = 1'b1;
    mq.delete();
    repeat (4) @(negedge i_clk);
    got_q.delete();
  endtask

  task automatic send_raw(input logic [7:0] d, input bit stop_ok);
    i_rx = 1'b0;
    repeat (BIT) @(negedge i_clk);
    for (int k = 0; k < 8; k++) begin
      i_rx = d[k];
      repeat (BIT) @(negedge i_clk);
    end
    if (stop_ok) begin
      i_rx = 1'b1;
      repeat (BIT + BIT/4) @(negedge i_clk);
    end else begin
      i_rx = 1'b0;
      repeat (BIT*5/8) @(negedge i_clk);
      i_rx = 1'b1;
      repeat (BIT*3/8 + BIT) @(negedge i_clk);
    end
  endtask

  task automatic expect_frame(input int exp, input string tag);
    int t;
    t = 0;
    while (got_q.size() == 0 && t < 14*BIT) begin
      @(negedge i_clk);
      t++;
    end
    chk({tag, "_frame_seen"}, (got_q.size() > 0), 1);
    if (got_q.size() > 0) chk(tag, got_q.pop_front(), exp);
    repeat (2*BIT) @(negedge i_clk);
    chk({tag, "_idle_after"}, o_tx, 1);
    chk({tag, "_extra_frames"}, got_q.size(), 0);
  endtask

  // Send a byte and feed the reference model; every third accepted byte must come back as a result.
  task automatic send(input logic [7:0] d, input bit stop_ok);
    int exp;
    string tag;
    send_raw(d, stop_ok);
`ifdef RX_FRAMING_CHECK_EN
    if (stop_ok) mq.push_back(d);
`else
    mq.push_back(d);
`endif
    if (mq.size() == 3) begin
      exp = ref_alu(mq[0], mq[1], mq[2]);
      tag = $sformatf("res_%02h_%02h_%02h", mq[0], mq[1], mq[2]);
      mq.delete();
      expect_frame(exp, tag);
    end
  endtask

  task automatic run3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    do_reset();
    chk("o_tx_idle_before", o_tx, 1);
    send(a, 1'b1);
    send(b, 1'b1);
    send(op, 1'b1);
  endtask

  logic [7:0] vec [0:11][0:2] = '{
    '{8'h03, 8'h08, 8'h20}, '{8'h03, 8'h08, 8'h22}, '{8'hFF, 8'h01, 8'h20},
    '{8'hF0, 8'h0F, 8'h24}, '{8'hF0, 8'h0F, 8'h25}, '{8'hF0, 8'h0F, 8'h26},
    '{8'hF0, 8'h0F, 8'h27}, '{8'h80, 8'h02, 8'h03}, '{8'h80, 8'h02, 8'h02},
    '{8'h05, 8'h06, 8'h3F}, '{8'h05, 8'h06, 8'hE0}, '{8'h7F, 8'h09, 8'h03}};
  int ops [0:7] = '{32, 34, 36, 37, 38, 39, 3, 2};

  initial begin
    logic [7:0] ra, rb, rop;
    do_reset();
    for (int i = 0; i < 12; i++) run3(vec[i][0], vec[i][1], vec[i][2]);

    // Byte before reset is forgotten.
    do_reset();
    send(8'h03, 1'b1);
    do_reset();
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h20, 1'b1);

    // Bad stop bit on the first byte.
    do_reset();
    send(8'h03, 1'b0);
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h20, 1'b1);

    // Reset in the middle of a reply frame forces the line idle at once and kills the frame.
    do_reset();
    send_raw(8'h10, 1'b1); send_raw(8'h20, 1'b1); send_raw(8'h20, 1'b1);
    repeat (2*BIT) @(negedge i_clk);
    chk("o_tx_low_mid_frame", o_tx, 0);
    i_reset = 1'b0;
    #1 chk("o_tx_reset_abort", o_tx, 1);
    #99 i_reset = 1'b1;
    mq.delete();
    repeat (12*BIT) @(negedge i_clk);
    chk("no_frame_after_abort", got_q.size(), 0);

    for (int i = 0; i < 6; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      rop = 8'(ops[$urandom_range(0, 7)] | ($urandom_range(0, 3) << 6));
      if ($urandom_range(0, 4) == 0) rop = 8'($urandom_range(0, 255));
      run3(ra, rb, rop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
